// File: rtl/shared_res_arbiter.sv
// Purpose : round-robin owner arbitration for one shared sub_block; drives its select mux via gnt/gnt_id.
// Latency : req seen in IDLE -> gnt/busy on the next edge; done/req-drop -> 1 dead cycle (RELEASE) + 1 IDLE cycle.
// Backpr. : none; the owner holds the resource until done, req drop or (optionally) watchdog revoke.
//
// Ports   : clk, rst (sync, active-high)
//           req[NUM_REQ]   level request per client
//           done[NUM_REQ]  completion strobe, only the owner's bit matters
//           gnt[NUM_REQ]   registered one-hot grant, zero when unowned
//           gnt_id[ID_W]   binary owner index, meaningful while busy
//           busy           high while a grant is held
//           timeout_err    1-cycle pulse in the RELEASE cycle of a watchdog revoke
// Build   : define SHARED_RES_ARB_TIMEOUT_EN to build the hold counter/watchdog;
//           otherwise timeout_err is tied low and MAX_HOLD has no effect.

module shared_res_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout_err
);

  // Elaboration-time parameter legality checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("shared_res_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("shared_res_arbiter: MAX_HOLD must be 2..255");
  end
  if (ID_W < 1 || ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("shared_res_arbiter: ID_W too narrow for NUM_REQ");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;

  logic               own_done;
  logic               own_req;
  logic               hold_max;

  assign own_done = done[owner_q];
  assign own_req  = req[owner_q];

  // Round-robin search: candidate index walks from ptr upward, wrapping at
  // NUM_REQ. One extra bit keeps the sum from aliasing for non-power-of-2 sizes.
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] win_id;
  logic            win_vld;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!win_vld && req[cand[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[ID_W-1:0];
      end
    end
  end

  // Next search start is the client after the one just released.
  logic [ID_W:0] ptr_inc;

  always_comb begin
    ptr_inc = {1'b0, owner_q} + (ID_W+1)'(1);
    if (ptr_inc >= (ID_W+1)'(NUM_REQ)) begin
      ptr_inc = '0;
    end
  end

`ifdef SHARED_RES_ARB_TIMEOUT_EN
  // Counts consecutive GRANT cycles: 1 on the first, MAX_HOLD on the last allowed.
  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign hold_max = (hold_cnt_q == 8'(MAX_HOLD));

  always_comb begin
    hold_cnt_d = '0;
    if (state_d == ST_GRANT) begin
      hold_cnt_d = (state_q == ST_GRANT) ? hold_cnt_q + 8'd1 : 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_max = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_vld) begin
          owner_d = win_id;
          gnt_d   = NUM_REQ'(1) << win_id;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // done/req-drop are checked first so a coincident done beats the watchdog.
        if (own_done || !own_req) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_RELEASE;
        end else if (hold_max) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_inc[ID_W-1:0];
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = owner_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_shared_res_arbiter.sv
// Purpose : directed self-checking bench for shared_res_arbiter (2- and 4-client instances).
// Latency : inputs driven 1 time unit after a rising edge, outputs checked at the same point.
// Backpr. : n/a.

module tb_shared_res_arbiter;

  logic       clk = 1'b0;
  logic       rst;

  logic [1:0] req2, done2, gnt2;
  logic [0:0] id2;
  logic       busy2, to2;

  logic [3:0] req4, done4, gnt4;
  logic [1:0] id4;
  logic       busy4, to4;

  int tests = 0;
  int fails = 0;

  logic [1:0] oh2;
  logic [3:0] oh4;
  int         exp_id;
  int         exp4 [4] = '{1, 3, 1, 3};

  shared_res_arbiter #(.NUM_REQ(2), .MAX_HOLD(4)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .req         (req2),
    .done        (done2),
    .gnt         (gnt2),
    .gnt_id      (id2),
    .busy        (busy2),
    .timeout_err (to2)
  );

  shared_res_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .req         (req4),
    .done        (done4),
    .gnt         (gnt4),
    .gnt_id      (id4),
    .busy        (busy4),
    .timeout_err (to4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req2  = '0;
    done2 = '0;
    req4  = '0;
    done4 = '0;
    tick();
    tick();

    // Reset state
    chk("rst_gnt2",  gnt2,  2'b00);
    chk("rst_id2",   id2,   1'b0);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_to2",   to2,   1'b0);
    chk("rst_gnt4",  gnt4,  4'b0000);
    chk("rst_busy4", busy4, 1'b0);
    rst = 1'b0;

    // Single requester: grant one edge after req, release via done
    req2 = 2'b01;
    tick();
    chk("a_gnt",  gnt2,  2'b01);
    chk("a_id",   id2,   1'b0);
    chk("a_busy", busy2, 1'b1);
    tick();
    tick();
    done2 = 2'b01;
    req2  = 2'b00;
    tick();
    chk("a_rel_gnt",  gnt2,  2'b00);
    chk("a_rel_busy", busy2, 1'b0);
    chk("a_rel_to",   to2,   1'b0);
    done2 = 2'b00;
    tick();
    chk("a_idle_gnt",  gnt2,  2'b00);
    chk("a_idle_busy", busy2, 1'b0);

    // done coinciding with the last allowed hold cycle: normal release
    req2 = 2'b10;
    tick();
    chk("c_gnt", gnt2, 2'b10);
    chk("c_id",  id2,  1'b1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("c_hold_gnt", gnt2, 2'b10);
    end
    done2 = 2'b10;
    tick();
    chk("c_rel_gnt", gnt2, 2'b00);
    chk("c_rel_to",  to2,  1'b0);
    done2 = 2'b00;
    req2  = 2'b00;
    tick();
    chk("c_idle_to", to2, 1'b0);

    // Client 1 never finishes; client 0 joins while 1 owns
    req2 = 2'b10;
    tick();
    chk("t_gnt1", gnt2, 2'b10);
    chk("t_id1",  id2,  1'b1);
    req2 = 2'b11;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("t_hold_gnt", gnt2, 2'b10);
      chk("t_hold_to",  to2,  1'b0);
    end
    tick();
`ifdef SHARED_RES_ARB_TIMEOUT_EN
    chk("t_revoke_gnt",  gnt2,  2'b00);
    chk("t_revoke_busy", busy2, 1'b0);
    chk("t_err_pulse",   to2,   1'b1);
    tick();
    chk("t_err_once", to2,  1'b0);
    chk("t_idle_gnt", gnt2, 2'b00);
    tick();
`else
    chk("t_no_wdog_gnt", gnt2, 2'b10);
    chk("t_no_wdog_to",  to2,  1'b0);
    req2 = 2'b01;
    tick();
    chk("t_drop_gnt", gnt2, 2'b00);
    chk("t_drop_to",  to2,  1'b0);
    tick();
    req2 = 2'b11;
    tick();
`endif
    chk("t_next_gnt0", gnt2, 2'b01);

    // Both requesting continuously: grants alternate with 2-cycle gaps
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      oh2    = 2'b01 << exp_id;
      chk("alt_gnt", gnt2, oh2);
      chk("alt_id",  id2,  exp_id);
      tick();
      tick();
      done2 = oh2;
      tick();
      chk("alt_gap1", gnt2, 2'b00);
      done2 = 2'b00;
      tick();
      chk("alt_gap2", gnt2, 2'b00);
      tick();
    end
    chk("alt_wrap", gnt2, 2'b01);

    // Reset mid-grant while ptr points at client 1
    req2 = 2'b00;
    tick();
    tick();
    req2 = 2'b01;
    tick();
    chk("r_pre_gnt", gnt2, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    chk("r_gnt",  gnt2,  2'b00);
    chk("r_busy", busy2, 1'b0);
    chk("r_to",   to2,   1'b0);
    rst  = 1'b0;
    req2 = 2'b11;
    tick();
    chk("r_ptr0_gnt", gnt2, 2'b01);
    chk("r_ptr0_id",  id2,  1'b0);
    req2 = 2'b00;
    tick();
    tick();

    // Four clients, 1 and 3 requesting; stray done bits from non-owners
    req4 = 4'b1010;
    tick();
    for (int k = 0; k < 4; k++) begin
      oh4 = 4'b0001 << exp4[k];
      chk("n4_gnt",  gnt4,  oh4);
      chk("n4_id",   id4,   exp4[k]);
      chk("n4_busy", busy4, 1'b1);
      done4 = ~oh4;
      tick();
      chk("n4_nonowner_done", gnt4, oh4);
      done4 = oh4;
      tick();
      chk("n4_rel_gnt", gnt4, 4'b0000);
      done4 = 4'b0000;
      tick();
      tick();
    end
    req4 = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
